// File: rtl/icache_sa.sv
// N-way set-associative instruction cache with true-LRU replacement, one-entry
// miss register that always completes accepted fills, and single-cycle flush.
module icache_sa #(
  parameter int unsigned NUM_SETS = 16,
  parameter int unsigned NUM_WAYS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] proc2Icache_addr,
  input  logic        proc2Icache_req,
  input  logic        Icache_flush,
  input  logic [3:0]  mem2Icache_response,
  input  logic [63:0] mem2Icache_data,
  input  logic [3:0]  mem2Icache_tag,
  output logic [31:0] Icache2proc_data,
  output logic        Icache2proc_valid,
  output logic [1:0]  Icache2mem_command,
  output logic [31:0] Icache2mem_addr,
  output logic        Icache_busy
);

  localparam int unsigned IW = $clog2(NUM_SETS);
  localparam int unsigned AW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned TW = 32 - 3 - IW;
  localparam int unsigned BW = 29;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_e;
  typedef logic [NUM_WAYS-1:0][AW-1:0] set_age_t;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]         valid_q, valid_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][AW-1:0] age_q, age_d, age_init;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TW-1:0] tag_q, tag_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][63:0]   data_q, data_d;

  state_e          state_q, state_d;
  logic [BW-1:0]   miss_blk_q, miss_blk_d;
  logic [3:0]      mem_tag_q, mem_tag_d;
  logic            drop_q, drop_d;
  logic [1:0]      cmd_q, cmd_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   req_idx, miss_idx;
  logic [TW-1:0]   req_tag, miss_tag;
  logic            hit_any, hit, fill_fire, fill_wr, victim_found;
  logic [AW-1:0]   hit_way, victim;
  logic [63:0]     hit_data;
  logic            unused_addr_bits;

  assign req_idx  = proc2Icache_addr[3+IW-1:3];
  assign req_tag  = proc2Icache_addr[31:3+IW];
  assign miss_idx = miss_blk_q[IW-1:0];
  assign miss_tag = miss_blk_q[BW-1:IW];
  assign unused_addr_bits = ^proc2Icache_addr[1:0];

  // Age 0 is MRU; the touched way goes to 0, younger ways age by one.
  function automatic set_age_t touch(input set_age_t ages, input logic [AW-1:0] way);
    set_age_t      res;
    logic [AW-1:0] old;
    res = ages;
    old = ages[way];
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (AW'(w) == way) res[w] = '0;
      else if (ages[w] < old) res[w] = ages[w] + AW'(1);
    end
    return res;
  endfunction

  always_comb begin
    for (int unsigned s = 0; s < NUM_SETS; s++)
      for (int unsigned w = 0; w < NUM_WAYS; w++)
        age_init[s][w] = AW'(w);
  end

  // Combinational tag match against the indexed set.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any  = 1'b1;
        hit_way  = AW'(w);
        hit_data = data_q[req_idx][w];
      end
    end
  end

  assign hit               = proc2Icache_req & hit_any;
  assign Icache2proc_valid = hit;
  assign Icache2proc_data  = proc2Icache_addr[2] ? hit_data[63:32] : hit_data[31:0];

  // Victim for the pending fill: first invalid way, else the oldest.
  always_comb begin
    victim       = '0;
    victim_found = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!valid_q[miss_idx][w] && !victim_found) begin
        victim       = AW'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++)
        if (age_q[miss_idx][w] == AW'(NUM_WAYS - 1)) victim = AW'(w);
    end
  end

  assign fill_fire = (state_q == S_WAIT) && (mem2Icache_tag == mem_tag_q);
  assign fill_wr   = fill_fire && !drop_q && !Icache_flush;

  always_comb begin
    state_d    = state_q;
    miss_blk_d = miss_blk_q;
    mem_tag_d  = mem_tag_q;
    drop_d     = drop_q;
    valid_d    = valid_q;
    age_d      = age_q;
    tag_d      = tag_q;
    data_d     = data_q;

    case (state_q)
      S_IDLE: begin
        if (proc2Icache_req && !hit_any && !Icache_flush) begin
          miss_blk_d = proc2Icache_addr[31:3];
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (mem2Icache_response != 4'd0) begin
          mem_tag_d = mem2Icache_response;
          state_d   = S_WAIT;
        end else if ((proc2Icache_addr[31:3] != miss_blk_q) || Icache_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (Icache_flush) drop_d = 1'b1;
        if (fill_fire) begin
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (hit) age_d[req_idx] = touch(age_d[req_idx], hit_way);
    if (fill_wr) begin
      valid_d[miss_idx][victim] = 1'b1;
      tag_d[miss_idx][victim]   = miss_tag;
      data_d[miss_idx][victim]  = mem2Icache_data;
      age_d[miss_idx]           = touch(age_d[miss_idx], victim);
    end
    // Flush wins over any same-cycle hit or fill update.
    if (Icache_flush) begin
      valid_d = '0;
      age_d   = age_init;
    end

    cmd_d  = (state_d == S_REQ) ? BUS_LOAD : BUS_NONE;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      age_q      <= age_init;
      state_q    <= S_IDLE;
      miss_blk_q <= '0;
      mem_tag_q  <= '0;
      drop_q     <= 1'b0;
      cmd_q      <= BUS_NONE;
      busy_q     <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      age_q      <= age_d;
      state_q    <= state_d;
      miss_blk_q <= miss_blk_d;
      mem_tag_q  <= mem_tag_d;
      drop_q     <= drop_d;
      cmd_q      <= cmd_d;
      busy_q     <= busy_d;
    end
  end

  // Payload arrays are qualified by valid bits and need no reset.
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign Icache2mem_command = cmd_q;
  assign Icache2mem_addr    = {miss_blk_q, 3'b000};
  assign Icache_busy        = busy_q;

endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: directed vector tables, hand-written miss/flush/reset
// sequences, and random traffic against a recency-stamp LRU cache model.
module tb_icache_sa;
  localparam int unsigned NS = 16;
  localparam int unsigned NW = 2;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] proc2Icache_addr;
  logic        proc2Icache_req;
  logic        Icache_flush;
  logic [3:0]  mem2Icache_response;
  logic [63:0] mem2Icache_data;
  logic [3:0]  mem2Icache_tag;
  logic [31:0] Icache2proc_data;
  logic        Icache2proc_valid;
  logic [1:0]  Icache2mem_command;
  logic [31:0] Icache2mem_addr;
  logic        Icache_busy;

  always #5 clock = ~clock;

  icache_sa #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clock(clock), .reset(reset),
    .proc2Icache_addr(proc2Icache_addr), .proc2Icache_req(proc2Icache_req),
    .Icache_flush(Icache_flush), .mem2Icache_response(mem2Icache_response),
    .mem2Icache_data(mem2Icache_data), .mem2Icache_tag(mem2Icache_tag),
    .Icache2proc_data(Icache2proc_data), .Icache2proc_valid(Icache2proc_valid),
    .Icache2mem_command(Icache2mem_command), .Icache2mem_addr(Icache2mem_addr),
    .Icache_busy(Icache_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_accept = 0;

  logic        act_valid, act_busy;
  logic [31:0] act_data, act_addr;
  logic [1:0]  act_cmd;

  // Reference model: lines keyed by full block address, LRU by touch stamps.
  bit          mv [NS][NW];
  logic [28:0] mb [NS][NW];
  logic [63:0] md [NS][NW];
  int          ms [NS][NW];
  int          stamp;
  int          mmode;   // 0 idle, 1 requesting, 2 waiting for data
  logic [28:0] mmiss;
  logic [3:0]  mtag;
  bit          mdrop;
  bit          minit = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 1'b0;
        ms[s][w] = -w;
      end
    mmode = 0; mmiss = '0; mtag = '0; mdrop = 1'b0; stamp = 1; minit = 1'b1;
  endtask

  task automatic cycle(input bit rst, input bit rq, input logic [31:0] a, input bit fl,
                       input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] dt);
    int s, hw, nm, vs, vw, lo;
    bit e_valid, e_busy, fire;
    logic [31:0] e_data;
    logic [1:0]  e_cmd;
    @(posedge clock);
    #1;
    reset = rst; proc2Icache_req = rq; proc2Icache_addr = a; Icache_flush = fl;
    mem2Icache_response = rsp; mem2Icache_tag = tg; mem2Icache_data = dt;
    s = int'(a[31:3] % NS);
    hw = -1; nm = 0;
    for (int w = 0; w < NW; w++)
      if (mv[s][w] && mb[s][w] == a[31:3]) begin hw = w; nm++; end
    e_valid = rq && (hw >= 0);
    e_data = '0;
    if (hw >= 0) e_data = a[2] ? md[s][hw][63:32] : md[s][hw][31:0];
    e_cmd  = (mmode == 1) ? BUS_LOAD : BUS_NONE;
    e_busy = (mmode != 0);
    @(negedge clock);
    act_valid = Icache2proc_valid; act_data = Icache2proc_data;
    act_cmd = Icache2mem_command; act_addr = Icache2mem_addr; act_busy = Icache_busy;
    if (minit) begin
      chk("model valid", 64'(act_valid), 64'(e_valid));
      if (e_valid) chk("model data", 64'(act_data), 64'(e_data));
      chk("model cmd", 64'(act_cmd), 64'(e_cmd));
      chk("model busy", 64'(act_busy), 64'(e_busy));
      if (e_cmd == BUS_LOAD) chk("model addr", 64'(act_addr), 64'({mmiss, 3'b000}));
      chk("model single match", 64'(nm <= 1), 64'd1);
    end
    if (act_cmd == BUS_LOAD && rsp != 4'd0) n_accept++;
    if (rst) begin
      m_reset();
    end else begin
      fire = (mmode == 2) && (tg == mtag);
      vs = int'(mmiss % NS);
      vw = -1;
      for (int w = 0; w < NW; w++) if (!mv[vs][w] && vw < 0) vw = w;
      if (vw < 0) begin
        lo = 0;
        for (int w = 1; w < NW; w++) if (ms[vs][w] < ms[vs][lo]) lo = w;
        vw = lo;
      end
      if (fl) begin
        for (int ss = 0; ss < NS; ss++)
          for (int w = 0; w < NW; w++) begin mv[ss][w] = 1'b0; ms[ss][w] = -w; end
      end else begin
        if (e_valid) ms[s][hw] = stamp++;
        if (fire && !mdrop) begin
          mv[vs][vw] = 1'b1; mb[vs][vw] = mmiss; md[vs][vw] = dt; ms[vs][vw] = stamp++;
        end
      end
      case (mmode)
        0: if (rq && hw < 0 && !fl) begin mmode = 1; mmiss = a[31:3]; end
        1: if (rsp != 4'd0) begin mmode = 2; mtag = rsp; end
           else if (a[31:3] != mmiss || fl) mmode = 0;
        default: begin
          if (fl) mdrop = 1'b1;
          if (fire) begin mmode = 0; mdrop = 1'b0; end
        end
      endcase
    end
  endtask

  typedef struct {
    bit rst; bit rq; logic [31:0] a; bit fl; logic [3:0] rsp; logic [3:0] tg; logic [63:0] dt;
    bit ck; bit ev; logic [31:0] ed; logic [1:0] ecmd; logic [31:0] ea; bit eb;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit rq, logic [31:0] a, logic [3:0] rsp, logic [3:0] tg,
                              logic [63:0] dt, bit ck, bit ev, logic [31:0] ed,
                              logic [1:0] ecmd, logic [31:0] ea, bit eb);
    vec_t v;
    v.rst = rst; v.rq = rq; v.a = a; v.fl = 1'b0; v.rsp = rsp; v.tg = tg; v.dt = dt;
    v.ck = ck; v.ev = ev; v.ed = ed; v.ecmd = ecmd; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].rq, tbl[i].a, tbl[i].fl, tbl[i].rsp, tbl[i].tg, tbl[i].dt);
      if (tbl[i].ck) begin
        chk($sformatf("%s[%0d] valid", nm, i), 64'(act_valid), 64'(tbl[i].ev));
        if (tbl[i].ev) chk($sformatf("%s[%0d] data", nm, i), 64'(act_data), 64'(tbl[i].ed));
        chk($sformatf("%s[%0d] cmd", nm, i), 64'(act_cmd), 64'(tbl[i].ecmd));
        if (tbl[i].ecmd == BUS_LOAD)
          chk($sformatf("%s[%0d] addr", nm, i), 64'(act_addr), 64'(tbl[i].ea));
        chk($sformatf("%s[%0d] busy", nm, i), 64'(act_busy), 64'(tbl[i].eb));
      end
    end
    tbl.delete();
  endtask

  task automatic fill(input logic [31:0] a, input logic [3:0] t, input logic [63:0] d);
    cycle(0, 1, a, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 1, a, 0, t, 4'd0, 64'd0);
    cycle(0, 0, a, 0, 4'd0, t, d);
  endtask

  task automatic probe(input string nm, input logic [31:0] a, input bit ev, input logic [31:0] ed);
    cycle(0, 1, a, 0, 4'd0, 4'd0, 64'd0);
    chk({nm, " valid"}, 64'(act_valid), 64'(ev));
    if (ev) chk({nm, " data"}, 64'(act_data), 64'(ed));
    cycle(0, 0, a ^ 32'h8, 0, 4'd0, 4'd0, 64'd0);
  endtask

  task automatic rst_cycle();
    cycle(1, 0, 32'h0, 0, 4'd0, 4'd0, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int unsigned sets[3];
    sets[0] = 0; sets[1] = 1; sets[2] = 5;
    reset = 1'b1; proc2Icache_req = 1'b0; proc2Icache_addr = '0; Icache_flush = 1'b0;
    mem2Icache_response = '0; mem2Icache_tag = '0; mem2Icache_data = '0;

    // Basic miss/fill at 0x100, then redirect-abandon of a fresh miss.
    tbl.push_back(mk(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, BUS_NONE, 0, 0));
    tbl.push_back(mk(0, 0, 32'h100, 0, 0, 0, 1, 0, 0, BUS_NONE, 0, 0));
    tbl.push_back(mk(0, 1, 32'h100, 0, 0, 0, 1, 0, 0, BUS_NONE, 0, 0));
    tbl.push_back(mk(0, 1, 32'h100, 0, 0, 0, 1, 0, 0, BUS_LOAD, 32'h100, 1));
    tbl.push_back(mk(0, 1, 32'h100, 3, 0, 0, 1, 0, 0, BUS_LOAD, 32'h100, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 32'h100, 0, 0, 0, 1, 0, 0, BUS_NONE, 0, 1));
    tbl.push_back(mk(0, 1, 32'h100, 0, 3, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 0, BUS_NONE, 0, 1));
    tbl.push_back(mk(0, 1, 32'h100, 0, 0, 0, 1, 1, 32'hCCCC_DDDD, BUS_NONE, 0, 0));
    tbl.push_back(mk(0, 1, 32'h104, 0, 0, 0, 1, 1, 32'hAAAA_BBBB, BUS_NONE, 0, 0));
    tbl.push_back(mk(0, 1, 32'h108, 0, 0, 0, 1, 0, 0, BUS_NONE, 0, 0));
    tbl.push_back(mk(0, 0, 32'h100, 0, 0, 0, 1, 0, 0, BUS_LOAD, 32'h108, 1));
    tbl.push_back(mk(0, 0, 32'h100, 0, 0, 0, 1, 0, 0, BUS_NONE, 0, 0));
    n_accept = 0;
    run_tbl("basic");
    chk("basic accepted loads", 64'(n_accept), 64'd1);

    // Delayed acceptance: BUS_LOAD held through three refusals.
    tbl.push_back(mk(1, 0, 32'h040, 0, 0, 0, 0, 0, 0, BUS_NONE, 0, 0));
    tbl.push_back(mk(0, 1, 32'h040, 0, 0, 0, 1, 0, 0, BUS_NONE, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 32'h040, 0, 0, 0, 1, 0, 0, BUS_LOAD, 32'h040, 1));
    tbl.push_back(mk(0, 1, 32'h040, 5, 0, 0, 1, 0, 0, BUS_LOAD, 32'h040, 1));
    tbl.push_back(mk(0, 1, 32'h040, 0, 0, 0, 1, 0, 0, BUS_NONE, 0, 1));
    tbl.push_back(mk(0, 1, 32'h040, 0, 9, 64'hDEAD_0000_BEEF_0000, 1, 0, 0, BUS_NONE, 0, 1));
    tbl.push_back(mk(0, 1, 32'h040, 0, 5, 64'h1111_2222_3333_4444, 1, 0, 0, BUS_NONE, 0, 1));
    tbl.push_back(mk(0, 1, 32'h040, 0, 0, 0, 1, 1, 32'h3333_4444, BUS_NONE, 0, 0));
    tbl.push_back(mk(0, 1, 32'h044, 0, 0, 0, 1, 1, 32'h1111_2222, BUS_NONE, 0, 0));
    run_tbl("delayed");

    // LRU replacement within set 0.
    rst_cycle();
    fill(32'h000, 4'd1, 64'h0000_0001_0000_0000);
    fill(32'h100, 4'd2, 64'h0000_0002_0000_0100);
    probe("lru touch 000", 32'h000, 1, 32'h0000_0000);
    fill(32'h200, 4'd3, 64'h0000_0003_0000_0200);
    probe("lru 000", 32'h000, 1, 32'h0000_0000);
    probe("lru 200", 32'h204, 1, 32'h0000_0003);
    probe("lru 100", 32'h100, 0, 32'h0);

    // Redirect while waiting: fill still lands at the original address.
    rst_cycle();
    cycle(0, 1, 32'h040, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 1, 32'h040, 0, 4'd2, 4'd0, 64'd0);
    cycle(0, 1, 32'h300, 0, 4'd0, 4'd0, 64'd0);
    chk("redir wait busy", 64'(act_busy), 64'd1);
    chk("redir wait cmd", 64'(act_cmd), 64'(BUS_NONE));
    cycle(0, 1, 32'h300, 0, 4'd0, 4'd2, 64'h5555_6666_7777_8888);
    chk("redir fill valid", 64'(act_valid), 64'd0);
    cycle(0, 1, 32'h300, 0, 4'd0, 4'd0, 64'd0);
    chk("redir idle busy", 64'(act_busy), 64'd0);
    cycle(0, 1, 32'h300, 0, 4'd0, 4'd0, 64'd0);
    chk("redir new miss cmd", 64'(act_cmd), 64'(BUS_LOAD));
    chk("redir new miss addr", 64'(act_addr), 64'h300);
    cycle(0, 0, 32'h040, 0, 4'd0, 4'd0, 64'd0);
    probe("redir 040", 32'h040, 1, 32'h7777_8888);

    // Flush: visible only from the next cycle; drops in-flight fills.
    rst_cycle();
    fill(32'h100, 4'd1, 64'h0123_4567_89AB_CDEF);
    cycle(0, 1, 32'h100, 1, 4'd0, 4'd0, 64'd0);
    chk("flush same-cycle valid", 64'(act_valid), 64'd1);
    cycle(0, 1, 32'h100, 0, 4'd0, 4'd0, 64'd0);
    chk("flush next-cycle valid", 64'(act_valid), 64'd0);
    cycle(0, 0, 32'h108, 0, 4'd0, 4'd0, 64'd0);
    fill(32'h100, 4'd1, 64'h0123_4567_89AB_CDEF);
    cycle(0, 1, 32'h040, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 1, 32'h040, 0, 4'd7, 4'd0, 64'd0);
    cycle(0, 1, 32'h040, 1, 4'd0, 4'd0, 64'd0);
    cycle(0, 0, 32'h040, 0, 4'd0, 4'd7, 64'hFFFF_EEEE_DDDD_CCCC);
    chk("flush drop fill busy", 64'(act_busy), 64'd1);
    cycle(0, 0, 32'h040, 0, 4'd0, 4'd0, 64'd0);
    chk("flush drop idle busy", 64'(act_busy), 64'd0);
    probe("flush 040", 32'h040, 0, 32'h0);
    probe("flush 100", 32'h100, 0, 32'h0);
    cycle(0, 1, 32'h040, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 1, 32'h040, 0, 4'd6, 4'd0, 64'd0);
    cycle(0, 0, 32'h040, 1, 4'd0, 4'd6, 64'h1212_3434_5656_7878);
    probe("flush with fill 040", 32'h040, 0, 32'h0);

    // Reset while waiting discards the outstanding tag.
    rst_cycle();
    cycle(0, 1, 32'h040, 0, 4'd0, 4'd0, 64'd0);
    cycle(0, 1, 32'h040, 0, 4'd4, 4'd0, 64'd0);
    cycle(0, 1, 32'h040, 0, 4'd0, 4'd0, 64'd0);
    rst_cycle();
    cycle(0, 0, 32'h040, 0, 4'd0, 4'd4, 64'h9999_8888_7777_6666);
    chk("reset cmd", 64'(act_cmd), 64'(BUS_NONE));
    chk("reset busy", 64'(act_busy), 64'd0);
    chk("reset valid", 64'(act_valid), 64'd0);
    cycle(0, 0, 32'h040, 0, 4'd0, 4'd0, 64'd0);
    chk("reset busy after tag", 64'(act_busy), 64'd0);
    probe("reset 040", 32'h040, 0, 32'h0);

    // Random traffic over a few conflicting sets.
    rst_cycle();
    ra = 32'h0;
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] rsp, tg;
      if ($urandom_range(0, 1) == 0)
        ra = (32'($urandom_range(0, 2)) << 7) | (32'(sets[$urandom_range(0, 2)]) << 3) |
             (32'($urandom_range(0, 1)) << 2);
      rsp = 4'd0;
      if ((mmode == 1 && $urandom_range(0, 2) == 0) || $urandom_range(0, 19) == 0)
        rsp = 4'($urandom_range(1, 15));
      tg = 4'd0;
      if (mmode == 2 && $urandom_range(0, 3) == 0) tg = mtag;
      else if ($urandom_range(0, 9) == 0) tg = 4'($urandom_range(1, 15));
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, ra,
            $urandom_range(0, 39) == 0, rsp, tg, {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
Parametrised set-associative successor to the direct-mapped instruction cache. It sits between the fetch stage and the shared memory bus and returns one 32-bit instruction per cycle on a hit. It adds N-way associativity with true-LRU replacement and a single-entry miss register that completes accepted fills even if fetch redirects. It also provides a one-cycle whole-cache flush. Block size stays at 8 bytes, matching the 64-bit memory data path.

Parameters:
NUM_SETS, 16, number of sets; power of 2, minimum 2; index width IW = log2(NUM_SETS).
NUM_WAYS, 2, ways per set; power of 2, 1 to 8; LRU age width AW = max(1, log2(NUM_WAYS)).
Derived: tag width TW = 32 - 3 - IW. Defaults give 32 lines = 256 bytes.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
proc2Icache_addr  in  `XLEN  fetch PC; bits [2:0] ignored except bit 2 (word select)
proc2Icache_req  in  1  fetch valid; no lookup, LRU update or miss is started when low
Icache_flush  in  1  invalidate all lines this cycle
mem2Icache_response  in  4  memory acceptance tag; 0 = request not accepted
mem2Icache_data  in  64  returned block
mem2Icache_tag  in  4  tag of data returned this cycle; 0 = no data
Icache2proc_data  out  32  selected instruction word
Icache2proc_valid  out  1  hit: req & tag match in a valid way of the indexed set
Icache2mem_command  out  BUS_COMMAND  BUS_LOAD while requesting, else BUS_NONE
Icache2mem_addr  out  `XLEN  {miss_addr[31:3], 3'b0}
Icache_busy  out  1  FSM not IDLE

Behaviour:
- Address split: tag = addr[31:3+IW], index = addr[3+IW-1:3], word = addr[2].
- Lookup is combinational. On a hit, Icache2proc_data = addr[2] ? data[63:32] : data[31:0] of the hitting way. When there is no hit, the data output is don't-care. At most one way may match; the bench asserts this.
- LRU: each line holds an AW-bit age; 0 = MRU. On req & hit, or on a fill, the touched way's age becomes 0. Ways with a smaller age than the old age increment; all others hold.
- Victim: the lowest-numbered invalid way; if none is invalid, the way with age NUM_WAYS-1.
- FSM states:
  - IDLE: on req & !hit & !flush, latch miss_addr = PC and go to REQ.
  - REQ: drive BUS_LOAD at miss_addr.
    - If mem2Icache_response != 0: latch mem_tag and go to WAIT.
    - Else, if the PC's block address != miss_addr's block address, or flush is high: abandon and go to IDLE. No request is outstanding in this case.
  - WAIT: command is BUS_NONE. When mem2Icache_tag == mem_tag (mem_tag never 0), write the block into the victim way chosen at that cycle for miss_addr's set, set it valid, make it MRU, and go to IDLE.
    - A PC change while in WAIT does not abort. The fill still lands at miss_addr's set and tag.
- Filled data is visible at the earliest in the cycle after the write; there is no bypass. An immediately repeated PC therefore hits one cycle after the fill cycle.
- A refetch of miss_addr in IDLE after a completed fill is a hit; no duplicate request is issued.
- Flush:
  - Valid bits clear at the next edge; ages are reset to way index.
  - If flush is high while in WAIT, set a drop flag. The matching fill is consumed (the FSM returns to IDLE) but nothing is written.
  - Flush in the same cycle as a fill also drops that fill.
  - While flush is high, Icache2proc_valid is still driven from the current array state; flush takes effect from the next cycle.
- Reset:
  - All valid bits = 0; ages = way index; FSM = IDLE; mem_tag = 0; drop flag = 0; miss_addr = 0.
  - Outputs after reset: command = BUS_NONE, Icache_busy = 0, Icache2proc_valid = 0.
  - Reset mid-miss discards the outstanding tag; a later matching memory return is ignored because the FSM is IDLE.
- In IDLE and REQ, mem2Icache_tag returns are ignored, including stale tags.

Test Plan:
- Reset, then req at PC 0x100, memory accepts with response 3 and returns tag 3 with data 0xAAAA_BBBB_CCCC_DDDD after 5 cycles -> BUS_LOAD at address 0x100 until accepted; the cycle after the fill, PC 0x100 gives valid=1, data 0xCCCC_DDDD, and PC 0x104 gives 0xAAAA_BBBB. Exactly one BUS_LOAD is accepted.
- Defaults: fill 0x000, 0x100 and 0x200 (all set 0), touching 0x000 between the 0x100 and 0x200 fills -> 0x200 evicts 0x100; 0x000 and 0x200 hit, 0x100 misses.
- Miss at 0x040 with response 0 for 3 cycles, then response 5 -> BUS_LOAD held 4 cycles, then BUS_NONE and busy=1 until tag 5 arrives.
- Miss at 0x040 accepted (tag 2), PC redirected to 0x300 before tag 2 returns -> 0x040 is filled; 0x300 misses only after the FSM returns to IDLE; 0x040 hits later.
- Flush asserted in WAIT (tag 7), then tag 7 returns -> no line becomes valid; 0x040 misses again; all earlier hits miss.
- Reset in WAIT, then tag returns -> no write, command stays BUS_NONE, busy=0.
